// File: rtl/fp_round_integer.sv
// fp_round_integer: pipelined IEEE-754 round-to-integral engine, generic in
// exponent and mantissa width, with per-sample rounding mode, an inexact flag
// and valid/ready flow control.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears valids and outputs)
//   in_valid   input sample present
//   in_ready   unit accepts the sample this cycle (pipeline enable)
//   a          operand, sign | exponent | mantissa
//   rm         rounding mode: 00 toward zero, 01 floor, 10 ceil, 11 nearest-even
//   out_valid  result present
//   out_ready  downstream accepts the result
//   c          a rounded to an integral value, same format
//   inexact    c differs numerically from a (never set for NaN/inf)
//
// Pipeline: S1 unpack/classify/mask, S2 split + increment decision,
// S3 add, renormalise, pack. All stages advance together on en.
module fp_round_integer #(
    parameter int EXP_BITS  = 5,
    parameter int MANT_BITS = 10,
    localparam int BITS     = 1 + EXP_BITS + MANT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [1:0]      rm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] c,
    output logic            inexact
);

    localparam int                    BIAS     = (1 << (EXP_BITS - 1)) - 1;
    localparam logic [31:0]           BIAS_W   = 32'(BIAS);
    localparam logic [31:0]           BIG_W    = 32'(BIAS + MANT_BITS);
    localparam logic [EXP_BITS-1:0]   BIAS_E   = EXP_BITS'(BIAS);
    localparam logic [EXP_BITS-1:0]   EXP_ONE  = {{(EXP_BITS-1){1'b0}}, 1'b1};
    localparam logic [MANT_BITS-1:0]  MANT_MSB = {1'b1, {(MANT_BITS-1){1'b0}}};
    localparam logic [1:0]            RM_RTZ   = 2'b00;
    localparam logic [1:0]            RM_DN    = 2'b01;
    localparam logic [1:0]            RM_UP    = 2'b10;
    localparam logic [1:0]            RM_RNE   = 2'b11;

    // Quiet a NaN by forcing the top mantissa bit, payload otherwise kept.
    function automatic logic [MANT_BITS-1:0] quiet_nan(input logic [MANT_BITS-1:0] m);
        return m | MANT_MSB;
    endfunction

    // Increment decision; 'near' is the precomputed nearest-even condition.
    function automatic logic round_up(input logic [1:0] mode, input logic sign,
                                      input logic frac, input logic near);
        logic r;
        case (mode)
            RM_RTZ:  r = 1'b0;
            RM_DN:   r = sign & frac;
            RM_UP:   r = ~sign & frac;
            RM_RNE:  r = near;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic en_s;
    logic out_valid_r;
    logic [BITS-1:0] c_r;
    logic inexact_r;

    assign en_s      = ~out_valid_r | out_ready;
    assign in_ready  = en_s;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign inexact   = inexact_r;

    // ---------------- Stage 1: unpack and classify ----------------
    logic                 a_sign_s;
    logic [EXP_BITS-1:0]  a_exp_s;
    logic [MANT_BITS-1:0] a_mant_s;
    logic [31:0]          exp_w_s;
    logic [31:0]          sh_s;
    logic                 nan_s;
    logic                 pass_s;
    logic                 small_s;
    logic                 half_s;
    logic [MANT_BITS-1:0] mask_s;

    // Classify operand and build the mask of discarded (fraction) mantissa bits.
    always_comb begin
        a_sign_s = a[BITS-1];
        a_exp_s  = a[BITS-2:MANT_BITS];
        a_mant_s = a[MANT_BITS-1:0];
        exp_w_s  = 32'(a_exp_s);
        sh_s     = exp_w_s - BIAS_W;
        nan_s    = (&a_exp_s) & (|a_mant_s);
        // Zero, inf and already-integral values pass through untouched.
        pass_s   = (&a_exp_s) | ((~|a_exp_s) & (~|a_mant_s)) | (exp_w_s >= BIG_W);
        small_s  = exp_w_s < BIAS_W;
        half_s   = exp_w_s == (BIAS_W - 32'd1);
        if (small_s) begin
            mask_s = {MANT_BITS{1'b1}};
        end else begin
            mask_s = {MANT_BITS{1'b1}} >> sh_s;
        end
    end

    logic                 s1_valid_r;
    logic                 s1_sign_r;
    logic [EXP_BITS-1:0]  s1_exp_r;
    logic [MANT_BITS-1:0] s1_mant_r;
    logic [1:0]           s1_rm_r;
    logic                 s1_nan_r;
    logic                 s1_pass_r;
    logic                 s1_small_r;
    logic                 s1_half_r;
    logic [MANT_BITS-1:0] s1_mask_r;

    // Stage 1 register; data loads only for a valid accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
        end else if (en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r  <= a_sign_s;
                s1_exp_r   <= a_exp_s;
                s1_mant_r  <= a_mant_s;
                s1_rm_r    <= rm;
                s1_nan_r   <= nan_s;
                s1_pass_r  <= pass_s;
                s1_small_r <= small_s;
                s1_half_r  <= half_s;
                s1_mask_r  <= mask_s;
            end
        end
    end

    // ---------------- Stage 2: split and decide increment ----------------
    logic [MANT_BITS-1:0] gmask_s;
    logic [MANT_BITS:0]   unit_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 lsb_s;
    logic                 frac_s;
    logic [MANT_BITS-1:0] n2_mant_s;
    logic                 n2_inc_s;
    logic                 n2_inexact_s;
    logic                 n2_small_s;

    // Guard is the top fraction bit; the integer LSB sits one above it and may
    // be the implicit leading one, hence the one-bit-wider unit vector.
    always_comb begin
        gmask_s      = s1_mask_r & ~(s1_mask_r >> 1'b1);
        unit_s       = {gmask_s, 1'b0};
        guard_s      = |(s1_mant_r & gmask_s);
        sticky_s     = |(s1_mant_r & (s1_mask_r >> 1'b1));
        lsb_s        = |({1'b1, s1_mant_r} & unit_s);
        frac_s       = |(s1_mant_r & s1_mask_r);
        n2_mant_s    = s1_mant_r;
        n2_inc_s     = 1'b0;
        n2_inexact_s = 1'b0;
        n2_small_s   = 1'b0;
        if (s1_nan_r) begin
            n2_mant_s = quiet_nan(s1_mant_r);
        end else if (s1_pass_r) begin
            n2_mant_s = s1_mant_r;
        end else if (s1_small_r) begin
            // |a| < 1 and nonzero: always inexact; nearest-even only rounds up
            // strictly above one half.
            n2_small_s   = 1'b1;
            n2_inexact_s = 1'b1;
            n2_inc_s     = round_up(s1_rm_r, s1_sign_r, 1'b1, s1_half_r & (|s1_mant_r));
        end else begin
            n2_mant_s    = s1_mant_r & ~s1_mask_r;
            n2_inexact_s = frac_s;
            n2_inc_s     = round_up(s1_rm_r, s1_sign_r, frac_s, guard_s & (sticky_s | lsb_s));
        end
    end

    logic                 s2_valid_r;
    logic                 s2_sign_r;
    logic [EXP_BITS-1:0]  s2_exp_r;
    logic [MANT_BITS-1:0] s2_mant_r;
    logic [MANT_BITS:0]   s2_unit_r;
    logic                 s2_inc_r;
    logic                 s2_inexact_r;
    logic                 s2_small_r;

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r    <= s1_sign_r;
                s2_exp_r     <= s1_exp_r;
                s2_mant_r    <= n2_mant_s;
                s2_unit_r    <= unit_s;
                s2_inc_r     <= n2_inc_s;
                s2_inexact_r <= n2_inexact_s;
                s2_small_r   <= n2_small_s;
            end
        end
    end

    // ---------------- Stage 3: add, renormalise, pack ----------------
    logic [MANT_BITS:0]   sum_s;
    logic [EXP_BITS-1:0]  n3_exp_s;
    logic [MANT_BITS-1:0] n3_mant_s;

    // A carry out of the mantissa leaves the field all-zero and bumps the exponent.
    always_comb begin
        sum_s = {1'b0, s2_mant_r} + (s2_inc_r ? s2_unit_r : {(MANT_BITS+1){1'b0}});
        if (s2_small_r) begin
            n3_exp_s  = s2_inc_r ? BIAS_E : {EXP_BITS{1'b0}};
            n3_mant_s = {MANT_BITS{1'b0}};
        end else if (sum_s[MANT_BITS]) begin
            n3_exp_s  = s2_exp_r + EXP_ONE;
            n3_mant_s = sum_s[MANT_BITS-1:0];
        end else begin
            n3_exp_s  = s2_exp_r;
            n3_mant_s = sum_s[MANT_BITS-1:0];
        end
    end

    // Output register; holds while stalled by out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            c_r         <= {BITS{1'b0}};
            inexact_r   <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                c_r       <= {s2_sign_r, n3_exp_s, n3_mant_s};
                inexact_r <= s2_inexact_r;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_integer.sv
// Directed self-checking bench for fp_round_integer: a half-precision
// instance for most vectors, flow control and reset, plus a single-precision
// instance for the wide-format vectors.
module tb_fp_round_integer;

    logic        clk = 1'b0;
    logic        rst;
    logic        hp_in_valid, hp_in_ready, hp_out_valid, hp_out_ready, hp_inexact;
    logic [15:0] hp_a, hp_c;
    logic [1:0]  hp_rm;
    logic        sp_in_valid, sp_in_ready, sp_out_valid, sp_out_ready, sp_inexact;
    logic [31:0] sp_a, sp_c;
    logic [1:0]  sp_rm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_round_integer #(.EXP_BITS(5), .MANT_BITS(10)) dut_hp (
        .clk(clk), .rst(rst), .in_valid(hp_in_valid), .in_ready(hp_in_ready),
        .a(hp_a), .rm(hp_rm), .out_valid(hp_out_valid), .out_ready(hp_out_ready),
        .c(hp_c), .inexact(hp_inexact)
    );

    fp_round_integer #(.EXP_BITS(8), .MANT_BITS(23)) dut_sp (
        .clk(clk), .rst(rst), .in_valid(sp_in_valid), .in_ready(sp_in_ready),
        .a(sp_a), .rm(sp_rm), .out_valid(sp_out_valid), .out_ready(sp_out_ready),
        .c(sp_c), .inexact(sp_inexact)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Present one sample, then confirm the result appears exactly 3 cycles later.
    task automatic send_vec(input bit sp, input logic [31:0] av, input logic [1:0] rmv,
                            input logic [31:0] ec, input logic ei, input string tag);
        @(negedge clk);
        if (sp) begin
            sp_in_valid = 1'b1; sp_a = av; sp_rm = rmv;
        end else begin
            hp_in_valid = 1'b1; hp_a = av[15:0]; hp_rm = rmv;
        end
        #1;
        check_val({tag, ".rdy"}, 32'(sp ? sp_in_ready : hp_in_ready), 32'd1);
        @(negedge clk);
        hp_in_valid = 1'b0;
        sp_in_valid = 1'b0;
        @(negedge clk);
        check_val({tag, ".early"}, 32'(sp ? sp_out_valid : hp_out_valid), 32'd0);
        @(negedge clk);
        check_val({tag, ".valid"}, 32'(sp ? sp_out_valid : hp_out_valid), 32'd1);
        check_val({tag, ".c"}, sp ? sp_c : 32'(hp_c), ec);
        check_val({tag, ".inx"}, 32'(sp ? sp_inexact : hp_inexact), 32'(ei));
    endtask

    logic [15:0] spec_a [4];
    logic [15:0] spec_c [4];
    logic [15:0] st_a   [8];
    logic [1:0]  st_rm  [8];
    logic [16:0] st_exp [8];
    logic [31:0] pat;

    initial begin
        int sent;
        int got;
        bit prev_stall;

        rst = 1'b1;
        hp_in_valid = 1'b0; hp_a = 16'h0000; hp_rm = 2'b00; hp_out_ready = 1'b1;
        sp_in_valid = 1'b0; sp_a = 32'h0;    sp_rm = 2'b00; sp_out_ready = 1'b1;

        spec_a[0] = 16'h7C00; spec_c[0] = 16'h7C00;
        spec_a[1] = 16'hFC00; spec_c[1] = 16'hFC00;
        spec_a[2] = 16'h7C01; spec_c[2] = 16'h7E01;
        spec_a[3] = 16'h8000; spec_c[3] = 16'h8000;

        st_a[0] = 16'h4100; st_rm[0] = 2'b11; st_exp[0] = {1'b1, 16'h4000};
        st_a[1] = 16'h4100; st_rm[1] = 2'b10; st_exp[1] = {1'b1, 16'h4200};
        st_a[2] = 16'hC100; st_rm[2] = 2'b01; st_exp[2] = {1'b1, 16'hC200};
        st_a[3] = 16'h3800; st_rm[3] = 2'b10; st_exp[3] = {1'b1, 16'h3C00};
        st_a[4] = 16'hB4CD; st_rm[4] = 2'b10; st_exp[4] = {1'b1, 16'h8000};
        st_a[5] = 16'h3E00; st_rm[5] = 2'b11; st_exp[5] = {1'b1, 16'h4000};
        st_a[6] = 16'h63FF; st_rm[6] = 2'b11; st_exp[6] = {1'b1, 16'h6400};
        st_a[7] = 16'h7BFF; st_rm[7] = 2'b00; st_exp[7] = {1'b0, 16'h7BFF};
        pat = 32'b1011_0010_1101_1001_0110_0111_0100_1101;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst.ready", 32'(hp_in_ready), 32'd1);
        check_val("rst.valid", 32'(hp_out_valid), 32'd0);
        check_val("rst.c", 32'(hp_c), 32'd0);
        check_val("rst.inx", 32'(hp_inexact), 32'd0);
        check_val("rst.sp_valid", 32'(sp_out_valid), 32'd0);
        rst = 1'b0;

        // All four modes on 2.5
        send_vec(1'b0, 32'h4100, 2'b00, 32'h4000, 1'b1, "m00_2.5");
        send_vec(1'b0, 32'h4100, 2'b01, 32'h4000, 1'b1, "m01_2.5");
        send_vec(1'b0, 32'h4100, 2'b10, 32'h4200, 1'b1, "m10_2.5");
        send_vec(1'b0, 32'h4100, 2'b11, 32'h4000, 1'b1, "m11_2.5");
        // Negative and sub-one values
        send_vec(1'b0, 32'hC100, 2'b01, 32'hC200, 1'b1, "floor_-2.5");
        send_vec(1'b0, 32'hC100, 2'b00, 32'hC000, 1'b1, "trunc_-2.5");
        send_vec(1'b0, 32'h3800, 2'b11, 32'h0000, 1'b1, "rne_0.5");
        send_vec(1'b0, 32'h3800, 2'b10, 32'h3C00, 1'b1, "ceil_0.5");
        send_vec(1'b0, 32'hB4CD, 2'b10, 32'h8000, 1'b1, "ceil_-0.3");
        send_vec(1'b0, 32'h3E00, 2'b11, 32'h4000, 1'b1, "rne_1.5");
        // Carry and already-integral maximum
        send_vec(1'b0, 32'h63FF, 2'b11, 32'h6400, 1'b1, "rne_1023.5");
        for (int m = 0; m < 4; m++)
            send_vec(1'b0, 32'h7BFF, 2'(m), 32'h7BFF, 1'b0, $sformatf("max_m%0d", m));
        // Specials in all modes
        for (int s = 0; s < 4; s++)
            for (int m = 0; m < 4; m++)
                send_vec(1'b0, 32'(spec_a[s]), 2'(m), 32'(spec_c[s]), 1'b0,
                         $sformatf("spec%0d_m%0d", s, m));

        // Backpressure stream
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            @(negedge clk);
            hp_out_ready = pat[cyc % 32];
            if (sent < 8) begin
                hp_in_valid = 1'b1; hp_a = st_a[sent]; hp_rm = st_rm[sent];
            end else begin
                hp_in_valid = 1'b0;
            end
            #1;
            check_val("bp.ready", 32'(hp_in_ready), 32'(!(hp_out_valid && !hp_out_ready)));
            if (prev_stall)
                check_val("bp.hold_valid", 32'(hp_out_valid), 32'd1);
            if (hp_out_valid) begin
                check_val($sformatf("bp.res%0d", got), 32'({hp_inexact, hp_c}), 32'(st_exp[got]));
                if (hp_out_ready) got++;
            end
            prev_stall = hp_out_valid && !hp_out_ready;
            if (hp_in_valid && hp_in_ready) sent++;
        end
        hp_in_valid = 1'b0;
        hp_out_ready = 1'b1;
        check_val("bp.count", 32'(got), 32'd8);
        repeat (4) begin
            @(negedge clk);
            check_val("bp.no_dup", 32'(hp_out_valid), 32'd0);
        end

        // Reset with samples in flight
        @(negedge clk);
        hp_in_valid = 1'b1; hp_a = 16'h4100; hp_rm = 2'b00;
        @(negedge clk);
        hp_a = 16'h3E00; hp_rm = 2'b11;
        @(negedge clk);
        hp_a = 16'h63FF; hp_rm = 2'b11;
        @(negedge clk);
        hp_in_valid = 1'b0;
        hp_out_ready = 1'b0;
        #1;
        check_val("mrst.pre_valid", 32'(hp_out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mrst.valid", 32'(hp_out_valid), 32'd0);
        check_val("mrst.c", 32'(hp_c), 32'd0);
        check_val("mrst.inx", 32'(hp_inexact), 32'd0);
        check_val("mrst.ready", 32'(hp_in_ready), 32'd1);
        rst = 1'b0;
        hp_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("mrst.drain%0d", k), 32'(hp_out_valid), 32'd0);
        end

        // Single precision
        send_vec(1'b1, 32'h40200000, 2'b11, 32'h40000000, 1'b1, "sp_rne_2.5");
        send_vec(1'b1, 32'hBFC00000, 2'b01, 32'hC0000000, 1'b1, "sp_floor_-1.5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_round_integer.md
# fp_round_integer

Parametrised, pipelined floating-point round-to-integral unit. It replaces the fixed half/single integer-part wrappers with one engine generic in exponent and mantissa width. It adds per-sample rounding mode, an inexact flag and valid/ready backpressure. It sits in the Precision library beside the other fp arithmetic blocks and feeds fp-to-int converters and fractional-part logic.

## Interface
- EXP_BITS, 5, exponent field width (5 = half, 8 = single, 11 = double)
- MANT_BITS, 10, stored mantissa field width (10 = half, 23 = single, 52 = double)
- BITS (derived, localparam), 1+EXP_BITS+MANT_BITS, operand width; BIAS = 2^(EXP_BITS-1)-1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  unit accepts the sample this cycle
- a  in  BITS  IEEE-754 operand
- rm  in  2  rounding mode: 00 toward zero, 01 floor, 10 ceil, 11 nearest-even
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- c  out  BITS  a rounded to an integral value, same format
- inexact  out  1  c != a, numerically; always 0 for NaN/inf

## Operation
- Three-stage pipeline:
  - S1: unpack, classify (zero, subnormal, normal, inf, NaN), compute unbiased exponent e and fraction mask.
  - S2: split integer/fraction bits, derive guard and sticky, decide increment per rm and sign.
  - S3: add increment, renormalise on carry, pack.
- Cases:
  - e >= MANT_BITS (already integral, incl. max finite): c = a, inexact 0.
  - 0 <= e < MANT_BITS: clear the low MANT_BITS-e mantissa bits, then apply the increment.
  - e < 0 (|a| < 1, incl. subnormals): magnitude becomes 0 or 1.0 per mode; sign of a is always kept (ceil of -0.3 gives -0).
  - ±0 → unchanged, inexact 0. ±inf → unchanged, inexact 0.
  - NaN → same payload with mantissa MSB forced to 1 (quieted), inexact 0.
- Increment rules (frac = any discarded bit set):
  - Toward zero: never increment.
  - Floor: increment iff sign=1 and frac.
  - Ceil: increment iff sign=0 and frac.
  - Nearest-even: increment iff guard and (sticky or integer LSB). For e < 0: e = -1 with nonzero mantissa → 1.0; e = -1 with zero mantissa (exactly 0.5) → 0; otherwise → 0.
- Carry out of mantissa increments exponent, mantissa field becomes 0. Overflow to inf is impossible, since rounding only happens for e < MANT_BITS.
- inexact = frac, independent of increment.
- rm is sampled with a and travels with it; mode may change every sample.

## Timing
- Latency: 3 cycles from accepted input (in_valid & in_ready) to out_valid, with out_ready held high.
- Throughput: one sample per cycle.
- Pipeline enable en = !out_valid | out_ready. in_ready = en; all stages advance together when en = 1 and hold when en = 0.
- Bubbles propagate as valid = 0 stages. in_ready does not depend on in_valid.
- Stall: out_valid, c and inexact hold stable while out_valid & !out_ready.
- in_valid & !in_ready: sample is not captured; the source must hold it.
- Reset:
  - all stage valids, out_valid, c and inexact go to 0 on the first edge with rst = 1; in-flight samples are discarded.
  - in_ready = 1 during and after reset.
- Reset has priority over en in the same cycle.
- Data registers hold when their stage valid is 0, to save toggling; only the valid bits need reset.

## Test plan
- Half, all four modes on 2.5 (0x4100): rm=00 → 0x4000, 01 → 0x4000, 10 → 0x4200, 11 → 0x4000; inexact=1 for all; each result out_valid exactly 3 cycles after acceptance.
- Half, negative/sub-one values:
  - -2.5 (0xC100): rm=01 → 0xC200, rm=00 → 0xC000.
  - 0.5 (0x3800): rm=11 → 0x0000, rm=10 → 0x3C00.
  - -0.3 (0xB4CD): rm=10 → 0x8000.
  - 1.5 (0x3E00): rm=11 → 0x4000.
- Half carry/renormalise: 1023.5 (0x63FF) rm=11 → 0x6400, inexact=1. 65504 (0x7BFF) any rm → 0x7BFF, inexact=0.
- Specials: 0x7C00 → 0x7C00; 0xFC00 → 0xFC00; 0x7C01 → 0x7E01; 0x8000 → 0x8000; inexact=0 for all, all modes.
- Backpressure: stream 8 samples back-to-back with out_ready toggling pseudo-randomly → results in order, none lost or duplicated. Outputs stable during stalls; in_ready low exactly when out_valid & !out_ready.
- Reset mid-stream and single precision:
  - rst pulsed with 3 samples in flight → out_valid 0 next cycle, none of them emerge.
  - Then EXP_BITS=8, MANT_BITS=23: 2.5 (0x40200000) rm=11 → 0x40000000; -1.5 (0xBFC00000) rm=01 → 0xC0000000.
